// File: rtl/main_mem_responder.sv
// Word-addressed memory responder: single-cycle writes and fixed-latency pipelined reads.
// A read occupies a LATENCY-deep shift pipeline; a write waits until no read is in flight.
module main_mem_responder #(
  parameter int ADDR_W  = 8,
  parameter int LATENCY = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        MemoryRequest,
  input  logic        MemoryWriteEnable,
  input  logic [15:0] MemoryAddressIn,
  input  logic [15:0] MemoryDataIn,
  output logic        MemStall,
  output logic        MemDataValid,
  output logic [15:0] MemDataOut,
  output logic [15:0] MemAddressOut
);

  localparam int DEPTH = 1 << ADDR_W;

  // Handshake: a request is taken on a rising edge with MemoryRequest=1, rst=1 and
  // MemStall=0; while MemStall=1 the requester holds every request input unchanged.

  logic [15:0]        mem_q [DEPTH];
  logic [LATENCY-1:0] vld_q;
  logic [15:0]        addr_q [LATENCY];
  logic [15:0]        data_q [LATENCY];

  logic [ADDR_W-1:0] word_idx;
  logic              in_flight;
  logic              rd_accept;
  logic              wr_accept;
  logic              unused_addr_bits;

  assign word_idx         = MemoryAddressIn[ADDR_W:1];
  assign unused_addr_bits = ^{MemoryAddressIn[15:ADDR_W+1], MemoryAddressIn[0]};

  // The last stage drives the outputs; a read sitting there has already returned,
  // so only the earlier stages block a write.
  assign in_flight = |vld_q[LATENCY-2:0];

  assign MemStall  = rst & MemoryRequest & MemoryWriteEnable & in_flight;
  assign rd_accept = rst & MemoryRequest & ~MemoryWriteEnable;
  assign wr_accept = rst & MemoryRequest & MemoryWriteEnable & ~in_flight;

  // Storage has no reset so contents survive rst.
  always_ff @(posedge clk) begin
    if (wr_accept) begin
      mem_q[word_idx] <= MemoryDataIn;
    end
  end

  // Bubbles carry zero address/data, so the outputs are zero whenever not valid.
  always_ff @(posedge clk) begin
    if (!rst) begin
      vld_q <= '0;
      for (int i = 0; i < LATENCY; i++) begin
        addr_q[i] <= '0;
        data_q[i] <= '0;
      end
    end else begin
      vld_q     <= {vld_q[LATENCY-2:0], rd_accept};
      addr_q[0] <= rd_accept ? MemoryAddressIn : 16'h0000;
      data_q[0] <= rd_accept ? mem_q[word_idx] : 16'h0000;
      for (int i = 1; i < LATENCY; i++) begin
        addr_q[i] <= addr_q[i-1];
        data_q[i] <= data_q[i-1];
      end
    end
  end

  assign MemDataValid  = vld_q[LATENCY-1];
  assign MemDataOut    = data_q[LATENCY-1];
  assign MemAddressOut = addr_q[LATENCY-1];

endmodule

// File: tb/tb_main_mem_responder.sv
// Bench for main_mem_responder: directed vector table, randomized traffic against a
// queue-based reference model, and a short LATENCY=2 back-to-back sequence.
module tb_main_mem_responder;

  localparam int L  = 4;
  localparam int AW = 8;

  logic        clk = 1'b0;
  logic        rst, req, we;
  logic [15:0] addr, wdata;
  logic        stall, vld;
  logic [15:0] dout, aout;

  logic        req2, we2;
  logic [15:0] addr2, wdata2;
  logic        stall2, vld2;
  logic [15:0] dout2, aout2;

  always #5 clk = ~clk;

  main_mem_responder #(.ADDR_W(AW), .LATENCY(L)) dut (
    .clk(clk), .rst(rst), .MemoryRequest(req), .MemoryWriteEnable(we),
    .MemoryAddressIn(addr), .MemoryDataIn(wdata), .MemStall(stall),
    .MemDataValid(vld), .MemDataOut(dout), .MemAddressOut(aout)
  );

  main_mem_responder #(.ADDR_W(AW), .LATENCY(2)) dut2 (
    .clk(clk), .rst(rst), .MemoryRequest(req2), .MemoryWriteEnable(we2),
    .MemoryAddressIn(addr2), .MemoryDataIn(wdata2), .MemStall(stall2),
    .MemDataValid(vld2), .MemDataOut(dout2), .MemAddressOut(aout2)
  );

  int checks   = 0;
  int failures = 0;
  int k        = 0;

  // Reference: word array plus a queue of pending returns {due_cycle, addr, data}.
  logic [15:0] ref_mem [256];
  logic [47:0] exp_q [$];

  typedef struct {
    logic        r, q, w;
    logic [15:0] a, d;
    logic        es, ev;
    logic [15:0] ed, ea;
  } vec_t;
  vec_t tbl [$];

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s cycle=%0d actual=%h expected=%h", name, k, act, exp);
    end
  endtask

  task automatic set_in(input logic r, input logic q, input logic w,
                        input logic [15:0] a, input logic [15:0] d);
    rst = r; req = q; we = w; addr = a; wdata = d;
    #1;
  endtask

  function automatic logic model_stall();
    if (!rst || !req || !we) return 1'b0;
    foreach (exp_q[i]) if (int'(exp_q[i][47:32]) > k) return 1'b1;
    return 1'b0;
  endfunction

  task automatic model_check();
    logic        ev;
    logic [15:0] ed, ea;
    ev = 1'b0; ed = 16'h0; ea = 16'h0;
    if (exp_q.size() > 0 && int'(exp_q[0][47:32]) == k) begin
      ev = 1'b1; ea = exp_q[0][31:16]; ed = exp_q[0][15:0];
    end
    chk("stall", {15'b0, stall}, {15'b0, model_stall()});
    chk("valid", {15'b0, vld}, {15'b0, ev});
    chk("data", dout, ed);
    chk("addr", aout, ea);
  endtask

  task automatic tick();
    logic stl;
    stl = model_stall();
    if (exp_q.size() > 0 && int'(exp_q[0][47:32]) == k) void'(exp_q.pop_front());
    if (!rst) exp_q.delete();
    else if (req && !we) exp_q.push_back({16'(k + L), addr, ref_mem[addr[AW:1]]});
    else if (req && we && !stl) ref_mem[addr[AW:1]] = wdata;
    @(posedge clk); #1;
    k++;
  endtask

  task automatic add(input logic r, input logic q, input logic w, input logic [15:0] a,
                     input logic [15:0] d, input logic es, input logic ev,
                     input logic [15:0] ed, input logic [15:0] ea);
    vec_t v;
    v.r = r; v.q = q; v.w = w; v.a = a; v.d = d;
    v.es = es; v.ev = ev; v.ed = ed; v.ea = ea;
    tbl.push_back(v);
  endtask

  initial begin
    logic        hold;
    logic [7:0]  b;
    logic        rr, rq, rw;
    logic [15:0] ra, rd;

    req2 = 1'b0; we2 = 1'b0; addr2 = 16'h0; wdata2 = 16'h0;
    set_in(1'b0, 1'b0, 1'b0, 16'h0, 16'h0);
    @(posedge clk); @(posedge clk); #1;

    // Reset state, with a write request present while rst is low.
    set_in(1'b0, 1'b1, 1'b1, 16'h0010, 16'h5555);
    chk("rst_stall", {15'b0, stall}, 16'h0);
    chk("rst_valid", {15'b0, vld}, 16'h0);
    chk("rst_data", dout, 16'h0);
    chk("rst_addr", aout, 16'h0);
    tick();

    // Fill storage: words 0..3 = 1..4, word i otherwise = {i, ~i}.
    for (int i = 0; i < 256; i++) begin
      b = 8'(i);
      set_in(1'b1, 1'b1, 1'b1, 16'(i * 2), (i < 4) ? 16'(i + 1) : {b, ~b});
      model_check();
      tick();
    end

    //  r  q  w  addr     data      stall valid exp_data  exp_addr
    add(1, 1, 1, 16'h0010, 16'hBEEF, 0, 0, 16'h0000, 16'h0000); // r0 write
    add(1, 1, 0, 16'h0010, 16'h0000, 0, 0, 16'h0000, 16'h0000); // r1 read
    add(1, 0, 0, 16'h0000, 16'h0000, 0, 0, 16'h0000, 16'h0000);
    add(1, 0, 0, 16'h0000, 16'h0000, 0, 0, 16'h0000, 16'h0000);
    add(1, 0, 0, 16'h0000, 16'h0000, 0, 0, 16'h0000, 16'h0000);
    add(1, 0, 0, 16'h0000, 16'h0000, 0, 1, 16'hBEEF, 16'h0010); // r5 return
    add(1, 1, 0, 16'h0000, 16'h0000, 0, 0, 16'h0000, 16'h0000); // r6..r9 reads
    add(1, 1, 0, 16'h0002, 16'h0000, 0, 0, 16'h0000, 16'h0000);
    add(1, 1, 0, 16'h0004, 16'h0000, 0, 0, 16'h0000, 16'h0000);
    add(1, 1, 0, 16'h0006, 16'h0000, 0, 0, 16'h0000, 16'h0000);
    add(1, 0, 0, 16'h0000, 16'h0000, 0, 1, 16'h0001, 16'h0000);
    add(1, 0, 0, 16'h0000, 16'h0000, 0, 1, 16'h0002, 16'h0002);
    add(1, 0, 0, 16'h0000, 16'h0000, 0, 1, 16'h0003, 16'h0004);
    add(1, 0, 0, 16'h0000, 16'h0000, 0, 1, 16'h0004, 16'h0006);
    add(1, 1, 0, 16'h0020, 16'h0000, 0, 0, 16'h0000, 16'h0000); // r14 read
    add(1, 1, 1, 16'h0022, 16'hCAFE, 1, 0, 16'h0000, 16'h0000); // write stalls
    add(1, 1, 1, 16'h0022, 16'hCAFE, 1, 0, 16'h0000, 16'h0000);
    add(1, 1, 1, 16'h0022, 16'hCAFE, 1, 0, 16'h0000, 16'h0000);
    add(1, 1, 1, 16'h0022, 16'hCAFE, 0, 1, 16'h10EF, 16'h0020); // accepted here
    add(1, 1, 0, 16'h0022, 16'h0000, 0, 0, 16'h0000, 16'h0000); // r19 read
    add(1, 0, 0, 16'h0000, 16'h0000, 0, 0, 16'h0000, 16'h0000);
    add(1, 0, 0, 16'h0000, 16'h0000, 0, 0, 16'h0000, 16'h0000);
    add(1, 0, 0, 16'h0000, 16'h0000, 0, 0, 16'h0000, 16'h0000);
    add(1, 0, 0, 16'h0000, 16'h0000, 0, 1, 16'hCAFE, 16'h0022); // r23
    add(1, 1, 1, 16'h0041, 16'h1234, 0, 0, 16'h0000, 16'h0000); // r24 aliasing
    add(1, 1, 0, 16'h0040, 16'h0000, 0, 0, 16'h0000, 16'h0000);
    add(1, 1, 0, 16'h0240, 16'h0000, 0, 0, 16'h0000, 16'h0000);
    add(1, 0, 0, 16'h0000, 16'h0000, 0, 0, 16'h0000, 16'h0000);
    add(1, 0, 0, 16'h0000, 16'h0000, 0, 0, 16'h0000, 16'h0000);
    add(1, 0, 0, 16'h0000, 16'h0000, 0, 1, 16'h1234, 16'h0040);
    add(1, 0, 0, 16'h0000, 16'h0000, 0, 1, 16'h1234, 16'h0240);
    add(1, 1, 0, 16'h0030, 16'h0000, 0, 0, 16'h0000, 16'h0000); // r31 read
    add(1, 0, 0, 16'h0000, 16'h0000, 0, 0, 16'h0000, 16'h0000);
    add(0, 1, 1, 16'h0030, 16'hDEAD, 0, 0, 16'h0000, 16'h0000); // r33 reset + write
    add(1, 1, 0, 16'h0030, 16'h0000, 0, 0, 16'h0000, 16'h0000); // first edge out of reset
    add(1, 0, 0, 16'h0000, 16'h0000, 0, 0, 16'h0000, 16'h0000);
    add(1, 0, 0, 16'h0000, 16'h0000, 0, 0, 16'h0000, 16'h0000);
    add(1, 0, 0, 16'h0000, 16'h0000, 0, 0, 16'h0000, 16'h0000);
    add(1, 0, 0, 16'h0000, 16'h0000, 0, 1, 16'h18E7, 16'h0030);
    add(1, 0, 0, 16'h0000, 16'h0000, 0, 0, 16'h0000, 16'h0000);

    foreach (tbl[i]) begin
      set_in(tbl[i].r, tbl[i].q, tbl[i].w, tbl[i].a, tbl[i].d);
      model_check();
      chk("tbl_stall", {15'b0, stall}, {15'b0, tbl[i].es});
      chk("tbl_valid", {15'b0, vld}, {15'b0, tbl[i].ev});
      chk("tbl_data", dout, tbl[i].ed);
      chk("tbl_addr", aout, tbl[i].ea);
      tick();
    end

    // Random traffic; a stalled write is held until taken.
    hold = 1'b0;
    rr = 1'b1; rq = 1'b0; rw = 1'b0; ra = 16'h0; rd = 16'h0;
    for (int n = 0; n < 1500; n++) begin
      if (!hold) begin
        rr = ($urandom_range(0, 63) != 0);
        rq = ($urandom_range(0, 3) != 0);
        rw = ($urandom_range(0, 3) == 0);
        ra = 16'($urandom);
        rd = 16'($urandom);
      end
      set_in(rr, rq, rw, ra, rd);
      model_check();
      hold = model_stall();
      tick();
    end

    // LATENCY=2 instance: two writes, then two back-to-back reads.
    set_in(1'b1, 1'b0, 1'b0, 16'h0, 16'h0);
    req2 = 1'b1; we2 = 1'b1; addr2 = 16'h0002; wdata2 = 16'h1111; #1;
    model_check(); tick();
    addr2 = 16'h0004; wdata2 = 16'h2222; #1;
    model_check(); tick();
    we2 = 1'b0; addr2 = 16'h0002; #1;
    chk("l2_c0_valid", {15'b0, vld2}, 16'h0);
    model_check(); tick();
    addr2 = 16'h0004; #1;
    chk("l2_c1_valid", {15'b0, vld2}, 16'h0);
    model_check(); tick();
    req2 = 1'b0; addr2 = 16'h0; #1;
    chk("l2_c2_valid", {15'b0, vld2}, 16'h1);
    chk("l2_c2_data", dout2, 16'h1111);
    chk("l2_c2_addr", aout2, 16'h0002);
    model_check(); tick();
    chk("l2_c3_valid", {15'b0, vld2}, 16'h1);
    chk("l2_c3_data", dout2, 16'h2222);
    chk("l2_c3_addr", aout2, 16'h0004);
    model_check(); tick();
    chk("l2_c4_valid", {15'b0, vld2}, 16'h0);
    chk("l2_c4_data", dout2, 16'h0);
    chk("l2_c4_stall", {15'b0, stall2}, 16'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
